// File: rtl/start_chk_pkg.sv
// Shared types, defaults and configuration check for the start-window monitor.
package start_chk_pkg;

  typedef enum logic {IDLE, WAIT} chk_state_t;

  localparam int unsigned WINDOW_DEF = 20;
  localparam int unsigned CNT_W_DEF  = 16;

  // The counters must hold WINDOW itself, i.e. 2**CNT_W > WINDOW.
  function automatic bit cnt_w_ok(input int unsigned window, input int unsigned cnt_w);
    return (window >= 1) && (window <= 65535) && (cnt_w >= 1) && (cnt_w <= 32) &&
           (cnt_w >= $clog2(window + 1));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (inc_i && (q_q != {W{1'b1}})) q_d = q_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/start_window_checker.sv
// Monitors that start is sampled high within WINDOW edges of an arm request and
// reports a registered pass/fail verdict with latency and saturating statistics.
module start_window_checker
  import start_chk_pkg::*;
#(
  parameter int unsigned WINDOW = WINDOW_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             clr_err_i,
  output logic             busy_o,
  output logic             pass_o,
  output logic             fail_o,
  output logic [CNT_W-1:0] latency_o,
  output logic             err_sticky_o,
  output logic [CNT_W-1:0] pass_cnt_o,
  output logic [CNT_W-1:0] fail_cnt_o
);

  if (!cnt_w_ok(WINDOW, CNT_W)) begin : g_bad_cfg
    $error("start_window_checker: WINDOW must be 1..65535 and 2**CNT_W > WINDOW");
  end

  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW);

  chk_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] lat_q, lat_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             err_q, err_d;

  // cnt_q counts window edges already consumed; cnt_inc is the index of the current edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    pass_d  = 1'b0;
    fail_d  = 1'b0;
    cnt_inc = cnt_q + CNT_W'(1);
    case (state_q)
      IDLE: begin
        if (arm_i) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (start_i) begin
          state_d = IDLE;
          pass_d  = 1'b1;
          lat_d   = cnt_inc;
        end else if (cnt_inc == WIN_LAST) begin
          state_d = IDLE;
          fail_d  = 1'b1;
        end else begin
          cnt_d   = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
    // A fail on the same edge as clr_err keeps the error flagged.
    err_d = fail_d ? 1'b1 : (clr_err_i ? 1'b0 : err_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lat_q   <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_pass_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (pass_d),
    .q_o   (pass_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_fail_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (fail_d),
    .q_o   (fail_cnt_o)
  );

  assign busy_o       = (state_q == WAIT);
  assign pass_o       = pass_q;
  assign fail_o       = fail_q;
  assign latency_o    = lat_q;
  assign err_sticky_o = err_q;

endmodule

// File: tb/tb_start_window_checker.sv
// Bench for start_window_checker: directed scenarios plus random traffic against an
// edge-numbered reference model, on a WINDOW=20/CNT_W=16 and a WINDOW=3/CNT_W=2 instance.
module tb_start_window_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic arm = 1'b0, start = 1'b0, abort = 1'b0, clr = 1'b0;

  logic        busy1, pass1, fail1, err1;
  logic [15:0] lat1, pc1, fc1;
  logic        busy2, pass2, fail2, err2;
  logic [1:0]  lat2, pc2, fc2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  start_window_checker #(.WINDOW(20), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .arm_i(arm), .start_i(start), .abort_i(abort), .clr_err_i(clr),
    .busy_o(busy1), .pass_o(pass1), .fail_o(fail1), .latency_o(lat1),
    .err_sticky_o(err1), .pass_cnt_o(pc1), .fail_cnt_o(fc1)
  );

  start_window_checker #(.WINDOW(3), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .arm_i(arm), .start_i(start), .abort_i(abort), .clr_err_i(clr),
    .busy_o(busy2), .pass_o(pass2), .fail_o(fail2), .latency_o(lat2),
    .err_sticky_o(err2), .pass_cnt_o(pc2), .fail_cnt_o(fc2)
  );

  // Reference: edges are numbered; a window armed on edge a covers edges a+1..a+WINDOW.
  typedef struct {
    bit open;
    int arm_edge;
    int edge_n;
    bit pass;
    bit fail;
    bit err;
    int lat;
    int pc;
    int fc;
  } mdl_t;

  function automatic mdl_t step(input mdl_t m, input int win, input int maxc,
                                input bit a, input bit s, input bit ab, input bit c);
    mdl_t n;
    int   elapsed;
    n = m;
    n.edge_n = m.edge_n + 1;
    n.pass = 1'b0;
    n.fail = 1'b0;
    elapsed = n.edge_n - m.arm_edge;
    if (!m.open) begin
      if (a) begin
        n.open = 1'b1;
        n.arm_edge = n.edge_n;
      end
    end else if (ab) begin
      n.open = 1'b0;
    end else if (s) begin
      n.open = 1'b0;
      n.pass = 1'b1;
      n.lat = elapsed;
      if (n.pc < maxc) n.pc = n.pc + 1;
    end else if (elapsed == win) begin
      n.open = 1'b0;
      n.fail = 1'b1;
      if (n.fc < maxc) n.fc = n.fc + 1;
    end
    if (n.fail) n.err = 1'b1;
    else if (c) n.err = 1'b0;
    return n;
  endfunction

  mdl_t m1, m2;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m1 <= '{default: 0};
      m2 <= '{default: 0};
    end else begin
      m1 <= step(m1, 20, 65535, arm, start, abort, clr);
      m2 <= step(m2, 3, 3, arm, start, abort, clr);
    end
  end

  wire [51:0] obs1 = {busy1, pass1, fail1, err1, lat1, pc1, fc1};
  wire [51:0] exp1 = {m1.open, m1.pass, m1.fail, m1.err, 16'(m1.lat), 16'(m1.pc), 16'(m1.fc)};
  wire [9:0]  obs2 = {busy2, pass2, fail2, err2, lat2, pc2, fc2};
  wire [9:0]  exp2 = {m2.open, m2.pass, m2.fail, m2.err, 2'(m2.lat), 2'(m2.pc), 2'(m2.fc)};

  // Drive one cycle of inputs at the falling edge and return at the next falling edge.
  task automatic tick(input bit a, input bit s, input bit ab, input bit c);
    arm = a; start = s; abort = ab; clr = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    arm = 0; start = 0; abort = 0; clr = 0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs1 !== 52'd0) begin
      failures++;
      $display("FAIL reset_dut1: got %h want 0", obs1);
    end
    checks++;
    if (obs2 !== 10'd0) begin
      failures++;
      $display("FAIL reset_dut2: got %h want 0", obs2);
    end
  endtask

  task automatic test_pass_latency();
    bit saw_fail;
    saw_fail = 0;
    tick(1, 0, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      tick(0, i == 9, 0, 0);
      saw_fail |= fail1;
      checks++;
      if (obs1 !== exp1) begin
        failures++;
        $display("FAIL pass9_model edge%0d: got %h want %h", i, obs1, exp1);
      end
    end
    checks++;
    if ({pass1, lat1} !== {1'b1, 16'd9}) begin
      failures++;
      $display("FAIL pass9_latency: got pass=%b lat=%0d want pass=1 lat=9", pass1, lat1);
    end
    tick(0, 0, 0, 0);
    checks++;
    if ({pass1, busy1, saw_fail, fail1} !== 4'b0000) begin
      failures++;
      $display("FAIL pass9_after: got pass=%b busy=%b fail=%b want 0", pass1, busy1, saw_fail | fail1);
    end
  endtask

  task automatic test_fail();
    tick(1, 0, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      tick(0, 0, 0, 0);
      checks++;
      if (obs1 !== exp1) begin
        failures++;
        $display("FAIL fail_model edge%0d: got %h want %h", i, obs1, exp1);
      end
    end
    checks++;
    if ({fail1, pass1, err1, fc1} !== {3'b101, 16'd1}) begin
      failures++;
      $display("FAIL fail_pulse: got fail=%b pass=%b err=%b fcnt=%0d want 1 0 1 1", fail1, pass1, err1, fc1);
    end
    tick(0, 0, 0, 0);
    checks++;
    if ({busy1, fail1} !== 2'b00) begin
      failures++;
      $display("FAIL fail_after: got busy=%b fail=%b want 0 0", busy1, fail1);
    end
  endtask

  task automatic test_boundary();
    tick(1, 0, 0, 0);
    for (int i = 1; i <= 20; i++) tick(0, i == 20, 0, 0);
    checks++;
    if ({pass1, fail1, lat1} !== {2'b10, 16'd20}) begin
      failures++;
      $display("FAIL edge20_pass: got pass=%b fail=%b lat=%0d want 1 0 20", pass1, fail1, lat1);
    end
    tick(1, 0, 0, 0);
    for (int i = 1; i <= 21; i++) begin
      tick(0, i == 21, 0, 0);
      if (i == 20) begin
        checks++;
        if ({pass1, fail1} !== 2'b01) begin
          failures++;
          $display("FAIL edge21_fail: got pass=%b fail=%b want 0 1", pass1, fail1);
        end
      end
    end
    checks++;
    if ({pass1, busy1, lat1} !== {2'b00, 16'd20}) begin
      failures++;
      $display("FAIL edge21_late: got pass=%b busy=%b lat=%0d want 0 0 20", pass1, busy1, lat1);
    end
  endtask

  task automatic test_abort();
    logic [15:0] pc0, fc0;
    pc0 = pc1; fc0 = fc1;
    tick(1, 0, 0, 0);
    for (int i = 1; i <= 5; i++) tick(0, i == 5, i == 5, 0);
    checks++;
    if ({pass1, fail1, busy1, pc1, fc1} !== {3'b000, pc0, fc0}) begin
      failures++;
      $display("FAIL abort: got p=%b f=%b b=%b pc=%0d fc=%0d want 0 0 0 %0d %0d",
               pass1, fail1, busy1, pc1, fc1, pc0, fc0);
    end
  endtask

  task automatic test_rst_mid_and_clr();
    tick(1, 0, 0, 0);
    for (int i = 1; i <= 9; i++) tick(0, 0, 0, 0);
    rst = 1'b1;
    #1;
    checks++;
    if (obs1 !== 52'd0) begin
      failures++;
      $display("FAIL rst_mid: got %h want 0", obs1);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({pass1, fail1} !== 2'b00) begin
      failures++;
      $display("FAIL rst_mid_pulse: got pass=%b fail=%b want 0 0", pass1, fail1);
    end
    rst = 1'b0;
    tick(1, 0, 0, 0);
    for (int i = 1; i <= 20; i++) tick(0, 0, 0, i == 20);
    checks++;
    if ({fail1, err1} !== 2'b11) begin
      failures++;
      $display("FAIL clr_vs_fail: got fail=%b err=%b want 1 1", fail1, err1);
    end
    tick(0, 0, 0, 1);
    checks++;
    if (err1 !== 1'b0) begin
      failures++;
      $display("FAIL clr_err: got err=%b want 0", err1);
    end
  endtask

  task automatic test_random();
    bit a, s, ab, c;
    for (int i = 0; i < 1500; i++) begin
      a  = ($urandom_range(2) == 0);
      s  = ($urandom_range(5) == 0);
      ab = ($urandom_range(24) == 0);
      c  = ($urandom_range(19) == 0);
      tick(a, s, ab, c);
      checks++;
      if (obs1 !== exp1) begin
        failures++;
        $display("FAIL rand_dut1 cyc%0d: got %h want %h", i, obs1, exp1);
      end
      checks++;
      if (obs2 !== exp2) begin
        failures++;
        $display("FAIL rand_dut2 cyc%0d: got %h want %h", i, obs2, exp2);
      end
      checks++;
      if ((pass1 && fail1) || (pass2 && fail2)) begin
        failures++;
        $display("FAIL rand_excl cyc%0d: got both pulses want at most one", i);
      end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1, 0, 0, 0);
      tick(0, 1, 0, 0);
      checks++;
      if (obs2 !== exp2) begin
        failures++;
        $display("FAIL sat_model pass%0d: got %h want %h", i, obs2, exp2);
      end
    end
    checks++;
    if (pc2 !== 2'd3) begin
      failures++;
      $display("FAIL sat_pass_cnt: got %0d want 3", pc2);
    end
    tick(0, 0, 0, 0);
    tick(1, 1, 0, 0);
    tick(0, 0, 0, 0);
    checks++;
    if ({pass2, busy2} !== 2'b01) begin
      failures++;
      $display("FAIL arm_start_same: got pass=%b busy=%b want 0 1", pass2, busy2);
    end
  endtask

  initial begin
    test_reset();
    test_pass_latency();
    test_fail();
    test_boundary();
    test_abort();
    test_rst_mid_and_clr();
    test_random();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
